// File: rtl/mantis_addnorm_if.sv
`default_nettype none
// ============================================================================
// Module   : mantis_addnorm_if
// Brief    : Operand-in / result-out handshake bundle for mantis_addnorm.
// Revision : 1.0 - initial release
// ============================================================================
interface mantis_addnorm_if #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23
);
    localparam int W = MANTIS_SIZE + 3;

    logic                in_valid;
    logic                in_ready;
    logic                sign_of_great;
    logic                sign_of_small;
    logic [EXP_SIZE-1:0] exp;
    logic [W-1:0]        mantis_great;
    logic [W-1:0]        mantis_small;
    logic                loss;

    logic                out_valid;
    logic                out_ready;
    logic                out_sign;
    logic [EXP_SIZE-1:0] out_exp;
    logic [W-1:0]        out_mantis;
    logic                out_overflow;
    logic                out_underflow;
    logic                out_inexact;

    modport master (
        output in_valid, sign_of_great, sign_of_small, exp,
               mantis_great, mantis_small, loss, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mantis,
               out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, sign_of_great, sign_of_small, exp,
               mantis_great, mantis_small, loss, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mantis,
               out_overflow, out_underflow, out_inexact
    );
endinterface
`default_nettype wire

// File: rtl/mantis_addnorm.sv
`default_nettype none
// ============================================================================
// Module   : mantis_addnorm
// Brief    : Effective mantissa add/subtract followed by 1-bit/cycle normalize.
// Revision : 1.0 - initial release
// ============================================================================
module mantis_addnorm #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mantis_addnorm_if.slave   bus
);
    localparam int W = MANTIS_SIZE + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                r_eff_sub;
    logic                r_sign_great;
    logic                r_loss;
    logic [W-1:0]        r_great;
    logic [W-1:0]        r_small;
    logic [W-1:0]        r_acc;
    logic [EXP_SIZE-1:0] r_exp;
    logic                r_sign;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_inexact;
    logic                r_valid;

    logic [W-1:0]        w_sum;
    logic [W-1:0]        w_diff;
    logic [EXP_SIZE-1:0] w_exp_inc;
    logic [EXP_SIZE-1:0] w_exp_dec;
    logic                w_zero;
    logic                w_carry;
    logic                w_normal;
    logic                w_exp_low;
    logic                w_accept;
    logic                w_release;

    assign w_sum     = r_great + r_small;
    assign w_diff    = r_great - r_small;
    assign w_exp_inc = r_exp + EXP_SIZE'(1);
    assign w_exp_dec = r_exp - EXP_SIZE'(1);
    assign w_zero    = (r_acc == '0);
    assign w_carry   = r_acc[W-1];
    assign w_normal  = r_acc[W-2];
    assign w_exp_low = (r_exp <= EXP_SIZE'(1));
    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_release = (r_state == DONE) && r_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.in_valid) w_next = ADD;
            ADD:  w_next = NORM;
            NORM: if (w_zero || w_carry || w_normal || w_exp_low) w_next = DONE;
            DONE: if (r_valid && bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eff_sub    <= 1'b0;
            r_sign_great <= 1'b0;
            r_loss       <= 1'b0;
            r_great      <= '0;
            r_small      <= '0;
            r_acc        <= '0;
            r_exp        <= '0;
            r_sign       <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_inexact    <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_eff_sub    <= bus.sign_of_great ^ bus.sign_of_small;
                        r_sign_great <= bus.sign_of_great;
                        r_loss       <= bus.loss;
                        r_great      <= bus.mantis_great;
                        r_small      <= bus.mantis_small;
                        r_exp        <= bus.exp;
                        r_overflow   <= 1'b0;
                        r_underflow  <= 1'b0;
                        r_inexact    <= bus.loss;
                    end
                end
                ADD: begin
                    // Loss folds into the sticky position so cancellation can never hide it.
                    r_acc  <= (r_eff_sub ? w_diff : w_sum) | {{(W-1){1'b0}}, r_loss};
                    r_sign <= r_sign_great;
                end
                NORM: begin
                    if (w_zero) begin
                        r_sign    <= 1'b0;
                        r_exp     <= '0;
                        r_acc     <= '0;
                        r_inexact <= r_loss;
                    end else if (w_carry) begin
                        r_exp     <= w_exp_inc;
                        r_inexact <= r_inexact | r_acc[0];
                        if (&w_exp_inc) begin
                            r_acc      <= '0;
                            r_overflow <= 1'b1;
                        end else begin
                            r_acc <= {1'b0, r_acc[W-1:2], r_acc[1] | r_acc[0]};
                        end
                    end else if (w_normal) begin
                        r_acc <= r_acc;
                    end else if (w_exp_low) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_acc <= {r_acc[W-2:0], 1'b0};
                        r_exp <= w_exp_dec;
                    end
                end
                DONE: begin
                    // Valid is raised one cycle after entering DONE; results are already settled.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (w_release) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_valid     = r_valid;
    assign bus.out_sign      = r_sign;
    assign bus.out_exp       = r_exp;
    assign bus.out_mantis    = r_acc;
    assign bus.out_overflow  = r_overflow;
    assign bus.out_underflow = r_underflow;
    assign bus.out_inexact   = r_inexact;

endmodule
`default_nettype wire

// File: doc/mantis_addnorm.md
Name: mantis_addnorm

Overview:
- Stage directly downstream of the exponent-align/swap preadder. It consumes that stage's ordered operands: sign of great/small, common exponent, aligned great/small mantissas and the alignment loss bit.
- Performs the effective mantissa add or subtract, then normalizes the result iteratively, one bit per cycle.
- Result goes to the rounding/packing stage over a valid/ready handshake.

Parameters:
- EXP_SIZE, default 8: exponent width.
- MANTIS_SIZE, default 23: stored fraction width. Internal mantissa width is W = MANTIS_SIZE+3 = 26.
  - bit W-1: carry headroom, 0 on input.
  - bit W-2: hidden bit.
  - bits W-3..1: fraction.
  - bit 0: guard/sticky.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: operand bundle valid.
- in_ready, output, 1: block can accept a bundle.
- sign_of_great, input, 1: sign of the larger-magnitude operand.
- sign_of_small, input, 1: sign of the smaller operand.
- exp, input, EXP_SIZE: common (aligned) exponent.
- mantis_great, input, W: larger aligned mantissa.
- mantis_small, input, W: smaller aligned mantissa.
- loss, input, 1: bits were shifted out during alignment.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_sign, output, 1: result sign.
- out_exp, output, EXP_SIZE: result exponent.
- out_mantis, output, W: normalized mantissa, with bit W-2 set unless zero or underflow.
- out_overflow, output, 1: exponent saturated.
- out_underflow, output, 1: normalization stopped at exponent 1 with hidden bit clear.
- out_inexact, output, 1: sticky bit of loss and any right-shifted-out bit.

Behaviour:
- One clock domain. Async reset forces:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - all result outputs and internal registers = 0.
  - Reset mid-operation discards the in-flight result.
- FSM states: IDLE, ADD, NORM, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch all inputs and go to ADD.
- ADD:
  - eff_sub = sign_of_great ^ sign_of_small.
  - acc = eff_sub ? mantis_great - mantis_small : mantis_great + mantis_small, computed at W bits. The great ≥ small ordering is guaranteed upstream, so there is no borrow.
  - acc[0] |= loss.
  - Result sign = sign_of_great. Go to NORM.
- NORM, evaluated once per cycle in this priority order:
  1. acc == 0: sign = 0, exp = 0, mantis = 0, inexact = loss; go to DONE.
  2. acc[W-1] = 1: acc = acc >> 1 with new bit0 = old bit1 | old bit0; exp + 1.
     - If the new exp is all-ones: mantis = 0, overflow = 1.
     - inexact |= old bit0. Go to DONE.
  3. acc[W-2] = 1: go to DONE.
  4. exp ≤ 1: underflow = 1; go to DONE, leaving the mantissa unnormalized.
  5. Otherwise: acc = acc << 1, exp - 1; stay in NORM.
- DONE:
  - out_valid = 1, and outputs are held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready = 0 in ADD, NORM and DONE. There is no same-cycle accept on result release; the next accept is possible the cycle after.
- Latency, counted from the accept edge:
  - out_valid rises 3 cycles later when the sum is already normalized or carries.
  - Each left shift adds 1 cycle, up to W-2 additional cycles.
- out_ready low holds the result indefinitely. out_ready high outside DONE is ignored.
- out_inexact = loss | any bit shifted out in step 2.

Test Plan:
- 1.0+1.0: sign 0/0, exp=127, great=small=26'h1000000 -> out_mantis=26'h1000000, out_exp=128, out_sign=0, out_valid 3 cycles after accept, all flags 0.
- 1.5−1.0: signs 0/1, exp=127, great=26'h1800000, small=26'h1000000 -> out_mantis=26'h1000000, out_exp=126, out_sign=0, out_valid 4 cycles after accept.
- Exact cancel: signs 1/0, exp=100, great=small=26'h1400000 -> out_sign=0, out_exp=0, out_mantis=0, out_valid 3 cycles after accept.
- Overflow: exp=254, 1.0+1.0 -> out_exp=255, out_mantis=0, out_overflow=1.
- Underflow and sticky: exp=2, signs 0/1, great=26'h1000001, small=26'h0C00000, loss=1:
  - ADD gives acc=26'h0400001, then one left shift gives acc=26'h0800002 with exp=1, then stop.
  - Required: out_exp=1, out_mantis=26'h0800002, out_underflow=1, out_inexact=1.
- Backpressure and reset: out_ready held low 10 cycles -> outputs stable and in_ready=0 throughout; rst pulsed while in NORM -> next cycle out_valid=0, in_ready=1, and a new bundle is accepted correctly.
